// File: rtl/oka_16bit_seq_ctrl_if.sv
// ----------------------------------------------------------------------------
// oka_16bit_seq_ctrl_if
//   Operand and result stream signals for the 16-bit sequenced OKA multiplier.
//   There are two valid/ready channels:
//     - in  : operand pair in_a/in_b goes from the source into the controller.
//     - out : the 31-bit product out_y goes from the controller to the sink.
//   Modports:
//     master : the source/sink side (the environment around the controller).
//     slave  : the controller side.
// ----------------------------------------------------------------------------
interface oka_16bit_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [30:0] out_y;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_y
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_y
  );
endinterface

// File: rtl/oka_16bit_seq_ctrl.sv
// ----------------------------------------------------------------------------
// oka_16bit_seq_ctrl
//   Computes a 16x16 GF(2) polynomial product (31-bit result). It shares one
//   external 8-bit multiplier across the three Karatsuba sub-products, one
//   after another:
//     z0 = al*bl, z2 = ah*bh, z1 = (al^ah)*(bl^bh)
//     y  = z0 ^ ((z0^z1^z2) << 8) ^ (z2 << 16)
// Parameters:
//   MUL_LAT      : latency of the shared multiplier in cycles (0..3).
//                  0 means the multiplier is combinational.
//   OP_COUNT_RST : value loaded into op_count on reset. Leave it at 0 for
//                  normal use. A non-zero value is a bring-up aid for
//                  exercising the counter wrap.
// Ports:
//   clk, rst     : clock; synchronous active-high reset.
//   bus          : in/out valid-ready streams (slave view).
//   mul_a, mul_b : operands to the shared 8-bit multiplier. They are held
//                  stable for a whole phase.
//   mul_y        : multiplier product, valid MUL_LAT cycles after mul_a/mul_b.
//   busy         : high whenever the controller is not idle.
//   op_count     : number of completed output handshakes; wraps silently.
// ----------------------------------------------------------------------------
module oka_16bit_seq_ctrl #(
  parameter int unsigned MUL_LAT      = 0,
  parameter logic [15:0] OP_COUNT_RST = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst,
  oka_16bit_seq_ctrl_if.slave   bus,
  output logic [7:0]            mul_a,
  output logic [7:0]            mul_b,
  input  logic [14:0]           mul_y,
  output logic                  busy,
  output logic [15:0]           op_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_MID,
    S_DONE
  } state_t;

  localparam logic [1:0] PHASE_LAST = 2'(MUL_LAT);

  state_t      state_q, state_nxt;
  logic [1:0]  phase_q;
  logic [15:0] a_q, b_q;
  logic [14:0] z0_q, z2_q;
  logic [30:0] out_y_q;
  logic [15:0] op_count_q;

  logic        in_ready;
  logic        out_valid;
  logic        phase_last;
  logic        accept;
  logic        emit;
  logic [14:0] z_mid;

  // Every sub-product phase lasts MUL_LAT+1 cycles. The product is taken in
  // the final cycle of the phase.
  assign phase_last = (phase_q == PHASE_LAST);
  assign accept     = bus.in_valid && in_ready;
  assign emit       = out_valid && bus.out_ready;

  // In the last MID cycle, mul_y is z1 itself. The result is therefore formed
  // straight from it, so z1 needs no register of its own.
  assign z_mid = z0_q ^ mul_y ^ z2_q;

  // State register and datapath.
  always_ff @(posedge clk) begin
    // NOTE: the reset clears every register, including the operand and
    // partial-product registers, so no stale data survives an aborted op.
    if (rst) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      z0_q       <= '0;
      z2_q       <= '0;
      out_y_q    <= '0;
      op_count_q <= OP_COUNT_RST;
    end else begin
      // NOTE: non-blocking assignments let every register update from the
      // values of the same cycle, whatever order the statements are in.
      state_q <= state_nxt;

      if ((state_q == S_LO || state_q == S_HI || state_q == S_MID) && !phase_last)
        phase_q <= phase_q + 2'd1;
      else
        phase_q <= '0;

      if (accept) begin
        a_q <= bus.in_a;
        b_q <= bus.in_b;
      end

      if (phase_last) begin
        case (state_q)
          S_LO:  z0_q <= mul_y;
          S_HI:  z2_q <= mul_y;
          S_MID: out_y_q <= {16'd0, z0_q} ^ {8'd0, z_mid, 8'd0} ^ {z2_q, 16'd0};
          default: ;
        endcase
      end

      if (emit)
        op_count_q <= op_count_q + 16'd1;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: a default first assignment gives every path a value, so no latch
    // is inferred.
    state_nxt = state_q;
    case (state_q)
      S_IDLE: if (bus.in_valid)      state_nxt = S_LO;
      S_LO:   if (phase_last)        state_nxt = S_HI;
      S_HI:   if (phase_last)        state_nxt = S_MID;
      S_MID:  if (phase_last)        state_nxt = S_DONE;
      S_DONE: if (bus.out_ready)     state_nxt = bus.in_valid ? S_LO : S_IDLE;
      default:                       state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state. The operand registers do not change during an
  // op, so mul_a/mul_b stay constant for the whole phase.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    mul_a     = '0;
    mul_b     = '0;
    case (state_q)
      S_IDLE: in_ready = 1'b1;
      S_LO: begin
        mul_a = a_q[7:0];
        mul_b = b_q[7:0];
      end
      S_HI: begin
        mul_a = a_q[15:8];
        mul_b = b_q[15:8];
      end
      S_MID: begin
        mul_a = a_q[7:0] ^ a_q[15:8];
        mul_b = b_q[7:0] ^ b_q[15:8];
      end
      S_DONE: begin
        out_valid = 1'b1;
        // A new op may be accepted only in the same cycle the result leaves.
        in_ready  = bus.out_ready;
      end
      default: ;
    endcase
  end

  assign busy          = (state_q != S_IDLE);
  assign op_count      = op_count_q;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_y     = out_y_q;

endmodule

// File: tb/tb_oka_16bit_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_oka_16bit_seq_ctrl
//   Self-checking bench for oka_16bit_seq_ctrl.
//   dut0: MUL_LAT=0, driven by a combinational 8-bit GF(2) multiplier model.
//   dut1: MUL_LAT=2, driven by a 2-stage registered multiplier model, with
//         op_count preloaded to 0xFFFF.
//   A scoreboard for dut0 queues the expected products at each input
//   handshake. It pops and compares them at each output handshake.
// ----------------------------------------------------------------------------
module tb_oka_16bit_seq_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Independent golden models. These are plain shift-and-xor loops.
  function automatic logic [14:0] gf_mul8(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] y = '0;
    for (int i = 0; i < 8; i++) if (b[i]) y ^= 15'(a) << i;
    return y;
  endfunction

  function automatic logic [30:0] gf_mul16(input logic [15:0] a, input logic [15:0] b);
    logic [30:0] y = '0;
    for (int i = 0; i < 16; i++) if (b[i]) y ^= 31'(a) << i;
    return y;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- dut0 : MUL_LAT = 0 ----------------
  oka_16bit_seq_ctrl_if if0 ();
  logic [7:0]  mul_a0, mul_b0;
  logic [14:0] mul_y0;
  logic        busy0;
  logic [15:0] op_count0;
  assign mul_y0 = gf_mul8(mul_a0, mul_b0);

  oka_16bit_seq_ctrl #(.MUL_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .bus(if0),
    .mul_a(mul_a0), .mul_b(mul_b0), .mul_y(mul_y0),
    .busy(busy0), .op_count(op_count0)
  );

  // ---------------- dut1 : MUL_LAT = 2 ----------------
  oka_16bit_seq_ctrl_if if1 ();
  logic [7:0]  mul_a1, mul_b1;
  logic [14:0] mul_y1, pipe1;
  logic        busy1;
  logic [15:0] op_count1;
  always @(posedge clk) begin
    pipe1  <= gf_mul8(mul_a1, mul_b1);
    mul_y1 <= pipe1;
  end

  oka_16bit_seq_ctrl #(.MUL_LAT(2), .OP_COUNT_RST(16'hFFFF)) dut1 (
    .clk(clk), .rst(rst), .bus(if1),
    .mul_a(mul_a1), .mul_b(mul_b1), .mul_y(mul_y1),
    .busy(busy1), .op_count(op_count1)
  );

  // ---------------- scoreboard / monitor for dut0 ----------------
  logic [30:0] sb_q[$];
  int          out_cycles[$];
  logic        bb_window = 1'b0;
  logic        busy_dropped = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (if0.out_valid && if0.out_ready) begin
        if (sb_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
        else                  check("sb_out_y", 32'(if0.out_y), 32'(sb_q.pop_front()));
        out_cycles.push_back(cyc_cnt);
      end
      if (if0.in_valid && if0.in_ready)
        sb_q.push_back(gf_mul16(if0.in_a, if0.in_b));
      if (bb_window && !busy0) busy_dropped = 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advances until dut0's out_valid is high. Returns the number of cycles.
  task automatic wait_out0(output int n);
    n = 0;
    while (!if0.out_valid && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("timeout_out_valid", 32'd0, 32'd1);
  endtask

  // One op on dut0: checks latency and result, then the handshake.
  task automatic run_op0(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic [30:0] exp_y);
    int n;
    logic [15:0] cnt;
    check({name, "_in_ready"}, 32'(if0.in_ready), 32'd1);
    if0.in_a = a; if0.in_b = b; if0.in_valid = 1'b1; if0.out_ready = 1'b1;
    tick();
    if0.in_valid = 1'b0;
    wait_out0(n);
    check({name, "_latency"}, 32'(n), 32'd3);
    check({name, "_y"}, 32'(if0.out_y), 32'(exp_y));
    cnt = op_count0;
    tick();
    check({name, "_op_count"}, 32'(op_count0), 32'(cnt + 16'd1));
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [30:0] y;
  } vec_t;
  vec_t vecs[7];

  initial begin
    int n;
    logic [15:0] cnt, ra, rb;
    logic [30:0] exp_y;
    logic        stable;

    vecs[0] = '{16'h0001, 16'h0001, 31'h00000001};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 31'h55555555};
    vecs[2] = '{16'h8000, 16'h8000, 31'h40000000};
    vecs[3] = '{16'h0100, 16'h0003, 31'h00000300};
    vecs[4] = '{16'h0003, 16'h0003, 31'h00000005};
    vecs[5] = '{16'h00FF, 16'h0100, 31'h0000FF00};
    vecs[6] = '{16'h0000, 16'hBEEF, 31'h00000000};

    rst = 1'b1;
    if0.in_valid = 1'b0; if0.in_a = '0; if0.in_b = '0; if0.out_ready = 1'b0;
    if1.in_valid = 1'b0; if1.in_a = '0; if1.in_b = '0; if1.out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state.
    check("rst_in_ready",  32'(if0.in_ready),  32'd1);
    check("rst_out_valid", 32'(if0.out_valid), 32'd0);
    check("rst_out_y",     32'(if0.out_y),     32'd0);
    check("rst_mul_ab",    32'({mul_a0, mul_b0}), 32'd0);
    check("rst_busy",      32'(busy0),         32'd0);
    check("rst_op_count",  32'(op_count0),     32'd0);
    check("rst1_op_count", 32'(op_count1),     32'hFFFF);

    // Table-driven single ops.
    foreach (vecs[i]) run_op0($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].y);
    check("vec_op_count", 32'(op_count0), 32'd7);

    // Backpressure: the result is held for 10 cycles with out_ready low.
    if0.out_ready = 1'b0;
    if0.in_a = 16'hA5C3; if0.in_b = 16'h3C5A; if0.in_valid = 1'b1;
    exp_y = gf_mul16(16'hA5C3, 16'h3C5A);
    tick();
    if0.in_valid = 1'b0;
    wait_out0(n);
    cnt = op_count0;
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (!if0.out_valid || if0.out_y !== exp_y || if0.in_ready || mul_a0 != 0 || mul_b0 != 0
          || op_count0 != cnt)
        stable = 1'b0;
      tick();
    end
    check("bp_stable", 32'(stable), 32'd1);
    check("bp_y", 32'(if0.out_y), 32'(exp_y));
    if0.out_ready = 1'b1;
    tick();
    check("bp_op_count", 32'(op_count0), 32'(cnt + 16'd1));
    check("bp_released", 32'(if0.out_valid), 32'd0);

    // Back-to-back: 8 random pairs with in_valid and out_ready held high.
    out_cycles.delete();
    busy_dropped = 1'b0;
    cnt = op_count0;
    if0.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      if0.in_a = ra; if0.in_b = rb;
      n = 0;
      while (!if0.in_ready && n < 50) begin tick(); n++; end
      if (n >= 50) check("timeout_in_ready", 32'd0, 32'd1);
      tick();
      bb_window = 1'b1;
    end
    if0.in_valid = 1'b0;
    wait_out0(n);
    tick();
    bb_window = 1'b0;
    check("b2b_results", 32'(out_cycles.size()), 32'd8);
    for (int i = 1; i < out_cycles.size(); i++)
      check($sformatf("b2b_spacing%0d", i), 32'(out_cycles[i] - out_cycles[i-1]), 32'd4);
    check("b2b_busy_held", 32'(busy_dropped), 32'd0);
    check("b2b_op_count", 32'(op_count0), 32'(cnt + 16'd8));

    // Reset while in HI: the op is discarded and no result follows.
    rst = 1'b1; tick(); rst = 1'b0;
    if0.in_a = 16'h1357; if0.in_b = 16'h2468; if0.in_valid = 1'b1;
    tick();                       // accepted, now in LO
    if0.in_valid = 1'b0;
    tick();                       // now in HI
    check("rh_busy_before", 32'(busy0), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rh_idle",      32'({busy0, if0.out_valid, if0.in_ready}), 32'b001);
    check("rh_op_count",  32'(op_count0), 32'd0);
    stable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (if0.out_valid) stable = 1'b0;
      tick();
    end
    check("rh_no_stale", 32'(stable), 32'd1);
    check("rh_sb_empty", 32'(sb_q.size()), 32'd0);
    run_op0("rh_next", 16'h1357, 16'h2468, gf_mul16(16'h1357, 16'h2468));

    // dut1: MUL_LAT=2, 3-cycle phases, 9-cycle latency, op_count wrap.
    check("d1_op_count_pre", 32'(op_count1), 32'hFFFF);
    if1.in_a = 16'h1234; if1.in_b = 16'hABCD; if1.in_valid = 1'b1;
    tick();
    if1.in_valid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      logic [15:0] exp_ab;
      exp_ab = (k < 3) ? 16'h34CD : (k < 6) ? 16'h12AB : 16'h2666;
      check($sformatf("d1_mul_ab_c%0d", k), 32'({if1.out_valid, mul_a1, mul_b1}),
            32'({1'b0, exp_ab}));
      tick();
    end
    check("d1_out_valid", 32'(if1.out_valid), 32'd1);
    check("d1_out_y", 32'(if1.out_y), 32'(gf_mul16(16'h1234, 16'hABCD)));
    if1.out_ready = 1'b1;
    tick();
    check("d1_op_count_wrap", 32'(op_count1), 32'h0000);
    check("d1_idle", 32'({busy1, if1.out_valid}), 32'd0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
